// File: rtl/forwarding_hazard_unit.sv
// Operand-bypass select and hazard stall control for a 5-stage pipeline.
// Chooses EX forwarding sources at ID and stalls on load-use and multi-cycle unit conflicts.
module forwarding_hazard_unit #(
    parameter int unsigned BIT_WIDTH         = 32,
    parameter int unsigned REG_ADDR_WIDTH    = 5,
    parameter int unsigned NUM_SRC           = 2,
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned MULDIV_CYCLES     = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              id_valid,
    input  logic [NUM_SRC*REG_ADDR_WIDTH-1:0] id_src,
    input  logic [NUM_SRC-1:0]                id_srcUsed,
    input  logic                              id_muldiv,
    input  logic                              ex_writeReg,
    input  logic                              ex_isLoad,
    input  logic [REG_ADDR_WIDTH-1:0]         ex_regToWrite,
    input  logic                              mem_writeReg,
    input  logic [REG_ADDR_WIDTH-1:0]         mem_regToWrite,
    input  logic                              wb_writeReg,
    input  logic [REG_ADDR_WIDTH-1:0]         wb_regToWrite,
    output logic                              stall,
    output logic                              ex_bubble,
    output logic [2*NUM_SRC-1:0]              forward,
    output logic [15:0]                       stall_count
);

    localparam int unsigned FWD_W  = 2 * NUM_SRC;
    localparam int unsigned CNT_W  = $clog2(MULDIV_CYCLES + 1);
    localparam int unsigned SCNT_W = 16;

    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_LOAD_STALL = 2'd1;
    localparam logic [1:0] ST_MD_BUSY    = 2'd2;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // The datapath width only has to be able to hold a register address.
    if (BIT_WIDTH < REG_ADDR_WIDTH) begin : g_bit_width_too_small
    end

    logic [NUM_SRC-1:0] live_c;
    logic [NUM_SRC-1:0] ex_hit_c;
    logic [NUM_SRC-1:0] mem_hit_c;
    logic [NUM_SRC-1:0] wb_hit_c;
    logic [FWD_W-1:0]   fwd_code_c;
    logic               load_use_c;

    // Per-source match against the producers; register 0 never matches.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        logic [REG_ADDR_WIDTH-1:0] src_addr;
        assign src_addr     = id_src[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
        assign live_c[i]    = id_valid & id_srcUsed[i] & (src_addr != '0);
        assign ex_hit_c[i]  = live_c[i] & ex_writeReg  & (src_addr == ex_regToWrite);
        assign mem_hit_c[i] = live_c[i] & mem_writeReg & (src_addr == mem_regToWrite);
        assign wb_hit_c[i]  = live_c[i] & wb_writeReg  & (src_addr == wb_regToWrite);
        // A WB producer is read through the write-first register file.
        assign fwd_code_c[2*i +: 2] = ex_hit_c[i]  ? FWD_MEM :
                                      mem_hit_c[i] ? FWD_WB  :
                                      wb_hit_c[i]  ? FWD_RF  : FWD_RF;
    end

    assign load_use_c = (|ex_hit_c) & ex_isLoad;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              stall_c;
    logic              md_req_c;
    logic              md_last_c;

    assign md_req_c  = id_valid & id_muldiv;
    assign md_last_c = (state_q == ST_MD_BUSY) && (cnt_q <= CNT_W'(1));

    // The final multi-cycle busy cycle frees the unit and is evaluated like RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_c = 1'b0;
        if ((state_q == ST_RUN) || md_last_c) begin
            if (load_use_c) begin
                stall_c = 1'b1;
                cnt_d   = CNT_W'(LOAD_STALL_CYCLES - 1);
                state_d = (LOAD_STALL_CYCLES > 1) ? ST_LOAD_STALL : ST_RUN;
            end else if (md_req_c) begin
                cnt_d   = CNT_W'(MULDIV_CYCLES);
                state_d = ST_MD_BUSY;
            end else begin
                cnt_d   = '0;
                state_d = ST_RUN;
            end
        end else begin
            case (state_q)
                ST_LOAD_STALL: begin
                    stall_c = 1'b1;
                    cnt_d   = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_RUN;
                    end
                end
                ST_MD_BUSY: begin
                    cnt_d   = cnt_q - CNT_W'(1);
                    stall_c = md_req_c | load_use_c;
                end
                default: begin
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            endcase
        end
    end

    assign stall = stall_c & ~rst;

    logic [FWD_W-1:0]  forward_q, forward_d;
    logic              ex_bubble_q, ex_bubble_d;
    logic [SCNT_W-1:0] stall_count_q, stall_count_d;

    always_comb begin
        forward_d     = stall_c ? '0 : fwd_code_c;
        ex_bubble_d   = stall_c;
        stall_count_d = stall_count_q;
        if (stall_c && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + SCNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            cnt_q         <= '0;
            forward_q     <= '0;
            ex_bubble_q   <= 1'b1;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            forward_q     <= forward_d;
            ex_bubble_q   <= ex_bubble_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign forward     = forward_q;
    assign ex_bubble   = ex_bubble_q;
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Scoreboard bench for forwarding_hazard_unit: directed per-cycle vectors push expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_forwarding_hazard_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [9:0]  id_src;
    logic [1:0]  id_srcUsed;
    logic        id_muldiv;
    logic        ex_writeReg;
    logic        ex_isLoad;
    logic [4:0]  ex_regToWrite;
    logic        mem_writeReg;
    logic [4:0]  mem_regToWrite;
    logic        wb_writeReg;
    logic [4:0]  wb_regToWrite;
    logic        stall;
    logic        ex_bubble;
    logic [3:0]  forward;
    logic [15:0] stall_count;

    forwarding_hazard_unit #(
        .BIT_WIDTH        (32),
        .REG_ADDR_WIDTH   (5),
        .NUM_SRC          (2),
        .LOAD_STALL_CYCLES(2),
        .MULDIV_CYCLES    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_src        (id_src),
        .id_srcUsed    (id_srcUsed),
        .id_muldiv     (id_muldiv),
        .ex_writeReg   (ex_writeReg),
        .ex_isLoad     (ex_isLoad),
        .ex_regToWrite (ex_regToWrite),
        .mem_writeReg  (mem_writeReg),
        .mem_regToWrite(mem_regToWrite),
        .wb_writeReg   (wb_writeReg),
        .wb_regToWrite (wb_regToWrite),
        .stall         (stall),
        .ex_bubble     (ex_bubble),
        .forward       (forward),
        .stall_count   (stall_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [3:0]  fwd;
        logic        bub;
        logic [15:0] cnt;
        string       name;
    } exp_t;

    exp_t        sb_q[$];
    int          n_vec = 0;
    int          n_miscmp = 0;
    logic [3:0]  pend_fwd;
    logic        pend_bub;
    logic [15:0] pend_cnt;

    task automatic check_field(input string nm, input string fld,
                               input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s.%s: got %h expected %h (t=%0t)", nm, fld, act, exp, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents outputs; compare against the oldest expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                n_vec++;
                check_field(e.name, "stall",       16'(stall),     16'(e.stall));
                check_field(e.name, "forward",     16'(forward),   16'(e.fwd));
                check_field(e.name, "ex_bubble",   16'(ex_bubble), 16'(e.bub));
                check_field(e.name, "stall_count", stall_count,    e.cnt);
            end
        end
    end

    // One cycle: drive inputs after the edge; es = expected stall, ec = forward code the
    // ID inputs deserve this cycle. Registered expectations appear one cycle later.
    task automatic step(input logic r, input logic v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] used, input logic md,
                        input logic exw, input logic exl, input logic [4:0] exr,
                        input logic mw, input logic [4:0] mr,
                        input logic ww, input logic [4:0] wr,
                        input logic es, input logic [3:0] ec, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        rst            = r;
        id_valid       = v;
        id_src         = {s1, s0};
        id_srcUsed     = used;
        id_muldiv      = md;
        ex_writeReg    = exw;
        ex_isLoad      = exl;
        ex_regToWrite  = exr;
        mem_writeReg   = mw;
        mem_regToWrite = mr;
        wb_writeReg    = ww;
        wb_regToWrite  = wr;
        e.stall = r ? 1'b0  : es;
        e.fwd   = r ? 4'h0  : pend_fwd;
        e.bub   = r ? 1'b1  : pend_bub;
        e.cnt   = r ? 16'h0 : pend_cnt;
        e.name  = nm;
        sb_q.push_back(e);
        if (r) begin
            pend_fwd = 4'h0;
            pend_bub = 1'b1;
            pend_cnt = 16'h0;
        end else begin
            pend_fwd = es ? 4'h0 : ec;
            pend_bub = es;
            pend_cnt = (!es || e.cnt == 16'hFFFF) ? e.cnt : e.cnt + 16'd1;
        end
    endtask

    initial begin : stimulus
        rst = 1'b1; id_valid = 1'b0; id_src = '0; id_srcUsed = '0; id_muldiv = 1'b0;
        ex_writeReg = 1'b0; ex_isLoad = 1'b0; ex_regToWrite = '0;
        mem_writeReg = 1'b0; mem_regToWrite = '0; wb_writeReg = 1'b0; wb_regToWrite = '0;
        pend_fwd = 4'h0; pend_bub = 1'b1; pend_cnt = 16'h0;

        //   r  v  s0 s1 used   md exw exl exr mw mr ww wr es  ec
        step(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "reset");
        step(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "reset_hold");
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "idle_after_reset");
        step(0, 1, 3, 0, 2'b01, 0, 1, 0, 3, 0, 0, 0, 0, 0, 4'b0010, "ex_alu_fwd");
        step(0, 1, 3, 0, 2'b01, 0, 1, 0, 3, 1, 3, 0, 0, 0, 4'b0010, "ex_and_mem_newest");
        step(0, 1, 3, 0, 2'b01, 0, 0, 0, 3, 1, 3, 0, 0, 0, 4'b0001, "mem_only");
        step(0, 1, 3, 0, 2'b01, 0, 1, 0, 4, 0, 0, 1, 3, 0, 4'b0000, "wb_only");
        step(0, 1, 3, 7, 2'b11, 0, 1, 0, 3, 1, 7, 0, 0, 0, 4'b0110, "two_sources");
        step(0, 1, 0, 0, 2'b01, 0, 1, 1, 0, 1, 0, 1, 0, 0, 4'b0000, "reg0_load");
        step(0, 1, 6, 6, 2'b00, 0, 1, 1, 6, 1, 6, 0, 0, 0, 4'b0000, "unused_src");
        step(0, 0, 6, 0, 2'b01, 0, 1, 1, 6, 0, 0, 0, 0, 0, 4'b0000, "invalid_id");
        step(0, 1, 0, 5, 2'b10, 0, 1, 1, 5, 0, 0, 0, 0, 1, 4'b1000, "load_use_1");
        step(0, 1, 0, 5, 2'b10, 0, 1, 1, 5, 0, 0, 0, 0, 1, 4'b1000, "load_use_2");
        step(0, 1, 0, 5, 2'b10, 0, 1, 0, 5, 0, 0, 0, 0, 0, 4'b1000, "load_release");
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "after_load");
        step(0, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "md_issue");
        step(0, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, "md_busy_1");
        step(0, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, "md_busy_2");
        step(0, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, "md_busy_3");
        step(0, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "md_accept");
        step(0, 1, 9, 0, 2'b01, 0, 0, 0, 0, 1, 9, 0, 0, 0, 4'b0001, "alu_during_md");
        step(0, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, "md_blocked");
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "md_drain_1");
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "md_drain_2");
        step(0, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "md_issue_2");
        step(1, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "reset_mid_md");
        step(0, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "md_after_reset");
        step(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "reset_again");
        step(0, 1, 0, 5, 2'b10, 0, 1, 1, 5, 0, 0, 0, 0, 1, 4'b1000, "load_use_pre_rst");
        step(1, 1, 0, 5, 2'b10, 0, 1, 1, 5, 0, 0, 0, 0, 0, 4'b0000, "reset_mid_load");
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "run_after_reset");

        // Continuous load-use keeps the pipeline stalled long enough to saturate the counter.
        for (int k = 0; k < 65540; k++) begin
            step(0, 1, 0, 5, 2'b10, 0, 1, 1, 5, 0, 0, 0, 0, 1, 4'b1000, "saturate");
        end
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "sat_hold_1");
        step(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, "sat_hold_2");

        repeat (2) @(posedge clk);
        if (sb_q.size() != 0) begin
            n_miscmp++;
            $display("FAIL drain: %0d expectations left, required 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
